// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants: widths, the fetch-buffer entry
// layout and the canonical NOP encoding.
package riscv_pkg;

  localparam int XLEN            = 32;
  localparam int INSTR_WIDTH     = 32;
  localparam int IMEM_DATA_WIDTH = 64;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetched memory word together with the PC of the next instruction in it.
  typedef struct packed {
    logic [IMEM_DATA_WIDTH-1:0] word;
    logic [XLEN-1:0]            pc;
  } fetch_entry_t;

  // Picks the instruction addressed by the entry PC out of its 64-bit word.
  function automatic logic [INSTR_WIDTH-1:0] entry_instr(input fetch_entry_t e);
    return e.pc[2] ? e.word[63:32] : e.word[31:0];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries. The head PC can be advanced in place
// so a word is consumed as two instructions before it is popped.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [IMEM_DATA_WIDTH-1:0] push_word,
  input  logic [XLEN-1:0]            push_pc,
  input  logic                       pop,
  input  logic                       head_adv,
  output logic [CNT_W-1:0]           count,
  output logic [IMEM_DATA_WIDTH-1:0] head_word,
  output logic [XLEN-1:0]            head_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The caller never pushes when full nor pops/advances when empty, so the
  // head update and the write can never target the same slot.
  always_comb begin
    mem_d = mem_q;
    if (head_adv) begin
      mem_d[rd_ptr_q].pc = mem_q[rd_ptr_q].pc + 32'd4;
    end
    if (push) begin
      mem_d[wr_ptr_q].word = push_word;
      mem_d[wr_ptr_q].pc   = push_pc;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count     = count_q;
  assign head_word = mem_q[rd_ptr_q].word;
  assign head_pc   = mem_q[rd_ptr_q].pc;

endmodule

// File: rtl/imem_fetch.sv
// Instruction-fetch front end: issues word reads to a 1-cycle synchronous
// instruction memory, buffers the words and hands out 32-bit instructions.
module imem_fetch
  import riscv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_WIDTH-1:0]   o_imem_addr,
  output logic [DATA_WIDTH-1:0]   o_imem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_imem_wen,
  input  logic [DATA_WIDTH-1:0]   i_imem_rdata,
  input  logic                    i_redirect,
  input  logic [31:0]             i_redirect_pc,
  output logic                    o_instr_valid,
  output logic [31:0]             o_instr,
  output logic [31:0]             o_instr_pc,
  input  logic                    i_instr_ready
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0]            fetch_pc_q, fetch_pc_d;
  logic                       inflight_q, inflight_d;
  logic [XLEN-1:0]            inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0]           buf_count;
  logic [CNT_W:0]             occupancy;
  logic [IMEM_DATA_WIDTH-1:0] head_word;
  logic [XLEN-1:0]            head_pc;
  fetch_entry_t               head_entry;
  logic                       issue;
  logic                       push;
  logic                       fire;
  logic                       head_adv;
  logic                       pop;
  logic                       instr_valid;

  // A read is only issued when its response is guaranteed a buffer slot, so the
  // memory never has to be stalled and the buffer can never overflow.
  always_comb begin
    occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q};
    issue     = !rst && !i_redirect && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
    push      = inflight_q && !i_redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc & ~32'h0000_0003;
    end else if (issue) begin
      fetch_pc_d    = {fetch_pc_q[31:3] + 29'd1, 3'b000};
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_redirect),
    .push      (push),
    .push_word (i_imem_rdata),
    .push_pc   (inflight_pc_q),
    .pop       (pop),
    .head_adv  (head_adv),
    .count     (buf_count),
    .head_word (head_word),
    .head_pc   (head_pc)
  );

  // Decode handshake: a transfer happens on an edge where o_instr_valid and
  // i_instr_ready are both high; while valid is high and ready low, valid, instr
  // and pc hold. Valid is dropped in a redirect or reset cycle so nothing
  // stale can transfer there.
  always_comb begin
    head_entry.word = head_word;
    head_entry.pc   = head_pc;
    instr_valid     = (buf_count != '0) && !i_redirect && !rst;
    fire            = instr_valid && i_instr_ready;
    head_adv        = fire && !head_pc[2];
    pop             = fire && head_pc[2];
  end

  assign o_imem_addr   = fetch_pc_q[ADDR_WIDTH+2:3];
  assign o_imem_wdata  = '0;
  assign o_imem_wen    = '0;
  assign o_instr_valid = instr_valid;
  assign o_instr       = instr_valid ? entry_instr(head_entry) : '0;
  assign o_instr_pc    = instr_valid ? head_pc : '0;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: a 1-cycle synchronous memory model, directed scenarios
// and a random phase, all judged against a sequential-PC reference stream.
module tb_imem_fetch;

  localparam int          ADDR_WIDTH = 11;
  localparam int          DATA_WIDTH = 64;
  localparam int          MEM_WORDS  = 2048;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [ADDR_WIDTH-1:0]   o_imem_addr;
  logic [DATA_WIDTH-1:0]   o_imem_wdata;
  logic [DATA_WIDTH/8-1:0] o_imem_wen;
  logic [DATA_WIDTH-1:0]   i_imem_rdata;
  logic                    i_redirect;
  logic [31:0]             i_redirect_pc;
  logic                    o_instr_valid;
  logic [31:0]             o_instr;
  logic [31:0]             o_instr_pc;
  logic                    i_instr_ready;

  logic [63:0] mem [MEM_WORDS];
  logic [63:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int n_fire   = 0;

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always @(posedge clk) i_imem_rdata <= mem[o_imem_addr];

  imem_fetch #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC),
    .BUF_DEPTH  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .o_imem_addr   (o_imem_addr),
    .o_imem_wdata  (o_imem_wdata),
    .o_imem_wen    (o_imem_wen),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready)
  );

  // ---------------- checking / reference ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    logic [63:0] w;
    w = mem[(pc / 8) % MEM_WORDS];
    return ((pc / 4) % 2 == 1) ? w[63:32] : w[31:0];
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] pc);
    return (pc / 8) % MEM_WORDS;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int          since = 0;
  logic        started = 1'b0;
  logic        rdy_run;
  logic        stall_prev;
  logic [31:0] prev_pc, prev_instr, next_pc;
  logic [63:0] exp_e;

  always @(negedge clk) begin
    if (rst) begin
      started    = 1'b1;
      since      = 0;
      next_pc    = RESET_PC;
      rdy_run    = 1'b1;
      stall_prev = 1'b0;
      exp_q.delete();
    end else if (started) begin
      if (i_redirect) begin
        check_eq("redirect_cycle_valid", o_instr_valid, 0);
        since      = 0;
        next_pc    = i_redirect_pc & ~32'h3;
        rdy_run    = 1'b1;
        stall_prev = 1'b0;
        exp_q.delete();
      end else begin
        if (since < 100000) since++;
        if (since == 1) begin
          check_eq("restart_addr", o_imem_addr, ref_addr(next_pc));
          check_eq("wdata_zero", o_imem_wdata, 0);
          check_eq("wen_zero", o_imem_wen, 0);
        end
        if (since == 1 || since == 2) check_eq("restart_gap_valid", o_instr_valid, 0);
        if (since == 3) check_eq("first_valid_lat", o_instr_valid, 1);
        else if (since > 3 && rdy_run) check_eq("sustained_valid", o_instr_valid, 1);
        if (since >= 3) rdy_run = rdy_run & i_instr_ready;
        if (!o_instr_valid) begin
          check_eq("idle_instr_zero", o_instr, 0);
          check_eq("idle_pc_zero", o_instr_pc, 0);
        end
        if (stall_prev) begin
          check_eq("stall_valid_hold", o_instr_valid, 1);
          check_eq("stall_pc_hold", o_instr_pc, prev_pc);
          check_eq("stall_instr_hold", o_instr, prev_instr);
        end
        if (o_instr_valid && i_instr_ready) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back({next_pc, ref_instr(next_pc)});
            next_pc = next_pc + 32'd4;
          end
          exp_e = exp_q.pop_front();
          check_eq("fire_pc", o_instr_pc, exp_e[63:32]);
          check_eq("fire_instr", o_instr, exp_e[31:0]);
          n_fire++;
        end
        stall_prev = o_instr_valid && !i_instr_ready;
        prev_pc    = o_instr_pc;
        prev_instr = o_instr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    tick();
    i_redirect    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] w;

  initial begin
    rst           = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_instr_ready = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h00500093_00000013;
    mem[1] = 64'h00A00113_00100193;

    // reset straight into streaming
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_valid", o_instr_valid, 0);
    check_eq("reset_addr", o_imem_addr, 0);
    tick();
    tick();
    check_eq("s0_pc", o_instr_pc, 32'h0);
    check_eq("s0_instr", o_instr, 32'h0000_0013);
    tick();
    check_eq("s1_pc", o_instr_pc, 32'h4);
    check_eq("s1_instr", o_instr, 32'h0050_0093);
    tick();
    check_eq("s2_pc", o_instr_pc, 32'h8);
    check_eq("s2_instr", o_instr, 32'h0010_0193);
    tick();
    check_eq("s3_pc", o_instr_pc, 32'hC);
    check_eq("s3_instr", o_instr, 32'h00A0_0113);
    repeat (6) tick();

    // backpressure right after the first valid
    do_reset();
    i_instr_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", o_instr_valid, 1);
      check_eq("bp_pc", o_instr_pc, 32'h0);
      check_eq("bp_addr_stopped", o_imem_addr, 2);
      tick();
    end
    i_instr_ready = 1'b1;
    repeat (12) tick();

    // redirect into the upper half of a word
    do_redirect(32'h0000_001C);
    check_eq("r1c_addr", o_imem_addr, 3);
    tick();
    check_eq("r1c_gap", o_instr_valid, 0);
    tick();
    w = mem[3];
    check_eq("r1c_valid", o_instr_valid, 1);
    check_eq("r1c_pc", o_instr_pc, 32'h1C);
    check_eq("r1c_instr", o_instr, w[63:32]);
    tick();
    w = mem[4];
    check_eq("r20_pc", o_instr_pc, 32'h20);
    check_eq("r20_instr", o_instr, w[31:0]);
    repeat (4) tick();

    // redirect with a full buffer and a read in flight
    i_instr_ready = 1'b0;
    repeat (6) tick();
    do_redirect(32'h0000_0040);
    i_instr_ready = 1'b1;
    repeat (12) tick();

    // back-to-back redirects: only the last target is delivered
    do_redirect(32'h0000_0100);
    do_redirect(32'h0000_0200);
    tick();
    check_eq("b2b_n3_valid", o_instr_valid, 0);
    tick();
    check_eq("b2b_n4_valid", o_instr_valid, 1);
    check_eq("b2b_n4_pc", o_instr_pc, 32'h200);
    repeat (6) tick();

    // reset while an instruction is stalled
    i_instr_ready = 1'b0;
    tick();
    tick();
    check_eq("mid_rst_pre_valid", o_instr_valid, 1);
    do_reset();
    check_eq("mid_rst_valid", o_instr_valid, 0);
    i_instr_ready = 1'b1;
    tick();
    tick();
    check_eq("mid_rst_r3_valid", o_instr_valid, 1);
    check_eq("mid_rst_r3_pc", o_instr_pc, RESET_PC);
    repeat (6) tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      i_redirect    = ($urandom_range(0, 29) == 0);
      i_redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31)))
                                                  : $urandom;
      i_instr_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst           = 1'b0;
    i_redirect    = 1'b0;
    i_instr_ready = 1'b1;
    repeat (10) tick();

    check_eq("fires_seen", (n_fire > 500), 1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
